// File: rtl/conv_pkg.sv
// Shared definitions for the wide/narrow width converters: FSM encoding and
// ratio/counter-width helpers.
package conv_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } conv_state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   function automatic int ratio_of(input int wide_w, input int narrow_w);
      return wide_w / narrow_w;
   endfunction

   // A count field must be at least one bit wide even for degenerate ratios.
   function automatic int cnt_w_of(input int ratio);
      return (clog2(ratio) < 1) ? 1 : clog2(ratio);
   endfunction

endpackage

// File: rtl/conv_wide_to_narrow.sv
// Single-clock serializer: one IN_W-bit word out as up to IN_W/OUT_W beats
// of OUT_W bits, valid/ready on both sides, partial words, selectable order.
module conv_wide_to_narrow
   import conv_pkg::*;
#(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int RATIO    = ratio_of(IN_W, OUT_W),
   localparam int CNT_W    = cnt_w_of(RATIO)
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   input  logic [CNT_W-1:0] in_count,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy
);

   // One extra bit so the remaining-beat counter can hold RATIO itself.
   localparam int RW = CNT_W + 1;

   if (RATIO < 2 || (IN_W % OUT_W) != 0) begin : g_bad_params
      $error("conv_wide_to_narrow: IN_W must be a multiple of OUT_W with a ratio of at least 2");
   end

   conv_state_e      state_q;
   conv_state_e      state_d;
   logic [IN_W-1:0]  shift_q;
   logic [RW-1:0]    remain_q;
   logic [RW-1:0]    load_beats;
   logic             load;
   logic             beat_done;

   function automatic logic [OUT_W-1:0] head_of(input logic [IN_W-1:0] word);
      if (MSB_FIRST) begin
         return word[IN_W-1 -: OUT_W];
      end
      return word[OUT_W-1:0];
   endfunction

   function automatic logic [IN_W-1:0] advance(input logic [IN_W-1:0] word);
      if (MSB_FIRST) begin
         return word << OUT_W;
      end
      return word >> OUT_W;
   endfunction

   assign beat_done  = out_valid && out_ready;
   assign in_ready   = (state_q == IDLE) || (beat_done && out_last);
   assign load       = in_valid && in_ready;
   assign load_beats = (in_count == '0) ? RW'(RATIO) : RW'(in_count);
   assign out_valid  = (state_q == SEND);
   assign busy       = (state_q == SEND);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Accepting a new word on the last-beat edge keeps us in SEND with no bubble.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (beat_done && out_last) begin
               state_d = load ? SEND : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // out_data is registered, so the shifter holds only the beats still to come.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         shift_q  <= '0;
         remain_q <= '0;
         out_data <= '0;
         out_last <= 1'b0;
      end else if (load) begin
         out_data <= head_of(in_data);
         shift_q  <= advance(in_data);
         remain_q <= load_beats;
         out_last <= (load_beats == RW'(1));
      end else if (beat_done) begin
         if (out_last) begin
            out_data <= '0;
            shift_q  <= '0;
            remain_q <= '0;
            out_last <= 1'b0;
         end else begin
            out_data <= head_of(shift_q);
            shift_q  <= advance(shift_q);
            remain_q <= remain_q - RW'(1);
            out_last <= (remain_q == RW'(2));
         end
      end
   end

endmodule

// File: tb/tb_conv_wide_to_narrow.sv
// Scoreboard bench: MSB-first and LSB-first builds driven in lockstep and
// checked against beat lists computed from the word and count.
module tb_conv_wide_to_narrow;

   localparam int IN_W  = 32;
   localparam int OUT_W = 8;
   localparam int RATIO = 4;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  count;
   } word_t;

   logic        clk       = 1'b0;
   logic        reset_L   = 1'b0;
   logic [31:0] in_data   = '0;
   logic        in_valid  = 1'b0;
   logic [1:0]  in_count  = '0;
   logic        out_ready = 1'b0;

   logic       in_ready_m, out_valid_m, out_last_m, busy_m;
   logic [7:0] out_data_m;
   logic       in_ready_l, out_valid_l, out_last_l, busy_l;
   logic [7:0] out_data_l;

   beat_t q_msb[$];
   beat_t q_lsb[$];
   word_t src_q[$];
   word_t pending_word;
   bit    pending = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   conv_wide_to_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .reset_L(reset_L),
      .in_data(in_data), .in_valid(in_valid), .in_count(in_count), .in_ready(in_ready_m),
      .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
      .out_last(out_last_m), .busy(busy_m)
   );

   conv_wide_to_narrow #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset_L(reset_L),
      .in_data(in_data), .in_valid(in_valid), .in_count(in_count), .in_ready(in_ready_l),
      .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
      .out_last(out_last_l), .busy(busy_l)
   );

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: timed out at %0t", name, $time);
   endtask

   // Reference: beat k of a word is byte k counted from the chosen end.
   task automatic push_word(input word_t w);
      int    n;
      beat_t b;
      n = (w.count == 2'd0) ? RATIO : int'(w.count);
      for (int k = 0; k < n; k++) begin
         b.last = (k == n - 1);
         b.data = 8'(w.data >> (IN_W - (k + 1) * OUT_W));
         q_msb.push_back(b);
         b.data = 8'(w.data >> (k * OUT_W));
         q_lsb.push_back(b);
      end
   endtask

   task automatic apply_stimulus(input bit oready, input bit gap);
      bit exp_ready;
      @(posedge clk);
      if (pending) begin
         push_word(pending_word);
         pending = 1'b0;
      end
      #1;
      in_valid  = (src_q.size() != 0) && !gap;
      if (src_q.size() != 0) begin
         in_data  = src_q[0].data;
         in_count = src_q[0].count;
      end
      out_ready = oready;
      #2;
      exp_ready = (q_msb.size() == 0) || (oready && q_msb[0].last);
      check_val("in_ready_msb", 32'(in_ready_m), 32'(exp_ready));
      check_val("in_ready_lsb", 32'(in_ready_l), 32'(exp_ready));
      if (in_valid && exp_ready) begin
         pending_word = src_q.pop_front();
         pending      = 1'b1;
      end
   endtask

   task automatic wait_head(input logic [7:0] val);
      int n;
      n = 0;
      while (!(q_msb.size() != 0 && q_msb[0].data == val) && n < 20) begin
         apply_stimulus(1'b1, 1'b0);
         n++;
      end
      if (n >= 20) begin
         fail_timeout("wait_head");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q_msb.size() != 0 || pending || src_q.size() != 0) && n < 200) begin
         apply_stimulus(1'b1, 1'b0);
         n++;
      end
      if (n >= 200) begin
         fail_timeout("drain");
      end
   endtask

   task automatic check_reset_outputs();
      check_val("rst_out_valid_msb", 32'(out_valid_m), 32'd0);
      check_val("rst_out_data_msb",  32'(out_data_m),  32'd0);
      check_val("rst_out_last_msb",  32'(out_last_m),  32'd0);
      check_val("rst_busy_msb",      32'(busy_m),      32'd0);
      check_val("rst_out_valid_lsb", 32'(out_valid_l), 32'd0);
      check_val("rst_out_data_lsb",  32'(out_data_l),  32'd0);
      check_val("rst_out_last_lsb",  32'(out_last_l),  32'd0);
      check_val("rst_busy_lsb",      32'(busy_l),      32'd0);
   endtask

   // Called right after a driver step, away from any clock edge.
   task automatic do_reset();
      reset_L  = 1'b0;
      in_valid = 1'b0;
      q_msb.delete();
      q_lsb.delete();
      src_q.delete();
      pending = 1'b0;
      #1;
      check_reset_outputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_L = 1'b1;
   endtask

   task automatic check_output();
      bit exp_v;
      exp_v = (q_msb.size() != 0);
      check_val("out_valid_msb", 32'(out_valid_m), 32'(exp_v));
      check_val("busy_msb",      32'(busy_m),      32'(exp_v));
      check_val("out_valid_lsb", 32'(out_valid_l), 32'(exp_v));
      check_val("busy_lsb",      32'(busy_l),      32'(exp_v));
      if (exp_v) begin
         check_val("out_data_msb", 32'(out_data_m), 32'(q_msb[0].data));
         check_val("out_last_msb", 32'(out_last_m), 32'(q_msb[0].last));
         check_val("out_data_lsb", 32'(out_data_l), 32'(q_lsb[0].data));
         check_val("out_last_lsb", 32'(out_last_l), 32'(q_lsb[0].last));
         if (out_ready) begin
            void'(q_msb.pop_front());
            void'(q_lsb.pop_front());
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         check_output();
      end
   end

   initial begin
      word_t w;
      #2;
      check_reset_outputs();
      @(posedge clk);
      #1;
      reset_L = 1'b1;
      #1;
      check_val("in_ready_after_reset_msb", 32'(in_ready_m), 32'd1);
      check_val("in_ready_after_reset_lsb", 32'(in_ready_l), 32'd1);

      $display("[TB] full word, out_ready high");
      w.data = 32'hA1B2C3D4; w.count = 2'd0; src_q.push_back(w);
      drain();

      $display("[TB] back-to-back words");
      w.data = 32'h11223344; w.count = 2'd0; src_q.push_back(w);
      w.data = 32'h55667788; w.count = 2'd0; src_q.push_back(w);
      drain();

      $display("[TB] backpressure on second beat");
      w.data = 32'hA1B2C3D4; w.count = 2'd0; src_q.push_back(w);
      wait_head(8'hA1);
      repeat (3) apply_stimulus(1'b0, 1'b0);
      drain();

      $display("[TB] partial words");
      w.data = 32'hA1B2C3D4; w.count = 2'd2; src_q.push_back(w);
      w.data = 32'hDEADBEEF; w.count = 2'd0; src_q.push_back(w);
      w.data = 32'hA1B2C3D4; w.count = 2'd3; src_q.push_back(w);
      w.data = 32'h0F1E2D3C; w.count = 2'd1; src_q.push_back(w);
      drain();

      $display("[TB] reset mid-word");
      w.data = 32'hA1B2C3D4; w.count = 2'd0; src_q.push_back(w);
      wait_head(8'hC3);
      do_reset();
      w.data = 32'hCAFEF00D; w.count = 2'd0; src_q.push_back(w);
      drain();

      $display("[TB] random traffic");
      for (int c = 0; c < 600; c++) begin
         if (src_q.size() < 2 && $urandom_range(0, 2) != 0) begin
            w.data  = $urandom;
            w.count = 2'($urandom_range(0, 3));
            src_q.push_back(w);
         end
         apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
      end
      drain();
      repeat (2) apply_stimulus(1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
